ub_pipe_cska: RTL



---
 rtl/ub_pipe_cska_if.sv | 25 ++
 rtl/ub_pipe_cska.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ub_pipe_cska_if.sv
// rtl/ub_pipe_cska_if.sv - operand/result handshake bundle for the pipelined carry-skip adder
interface ub_pipe_cska_if #(
  parameter int WIDTH = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_ci;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_s;
  logic             out_ovf;

  modport master (
    output in_valid, in_x, in_y, in_ci, in_sub, out_ready,
    input  in_ready, out_valid, out_s, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_y, in_ci, in_sub, out_ready,
    output in_ready, out_valid, out_s, out_ovf
  );
endinterface

// File: rtl/ub_pipe_cska.sv
// rtl/ub_pipe_cska.sv - pipelined carry-skip adder/subtractor with valid/ready stages
// Blocks of BLK bits ripple internally with a separate skip OR term; a register follows every PIPE_BLKS blocks.
module ub_pipe_cska #(
  parameter int WIDTH     = 11,
  parameter int BLK       = 2,
  parameter int PIPE_BLKS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ub_pipe_cska_if.slave bus
);
  localparam int NBLK  = (WIDTH + BLK - 1) / BLK;
  localparam int NSTG  = (NBLK + PIPE_BLKS - 1) / PIPE_BLKS;
  localparam int SBITS = PIPE_BLKS * BLK;

  function automatic logic [WIDTH-1:0] mask_from(input int lo);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= lo) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Stage k inputs: operands, carry and partial sum as seen by the blocks of stage k
  logic [WIDTH-1:0] xi [NSTG];
  logic [WIDTH-1:0] yi [NSTG];
  logic [WIDTH-1:0] si [NSTG];
  logic             ci [NSTG];
  logic             v  [NSTG];
  logic             rdy [NSTG+1];

  logic             blk_ci [NBLK];
  logic             blk_co [NBLK];
  logic [WIDTH-1:0] sum_all;

  for (genvar b = 0; b < NBLK; b++) begin : g_blk
    localparam int K  = b / PIPE_BLKS;
    localparam int LO = b * BLK;
    localparam int HI = ((b + 1) * BLK < WIDTH) ? (b + 1) * BLK : WIDTH;
    localparam int BW = HI - LO;

    logic [BW-1:0] bx;
    logic [BW-1:0] by;
    logic [BW-1:0] bs;
    logic          p;
    logic          rc;

    assign bx = xi[K][HI-1:LO];
    assign by = yi[K][HI-1:LO];

    if (b % PIPE_BLKS == 0) begin : g_first
      assign blk_ci[b] = ci[K];
    end else begin : g_chain
      assign blk_ci[b] = blk_co[b-1];
    end

    assign p = &(bx ^ by);

    always_comb begin : ripple
      logic c;
      c  = blk_ci[b];
      bs = '0;
      for (int i = 0; i < BW; i++) begin
        bs[i] = bx[i] ^ by[i] ^ c;
        c     = (bx[i] & by[i]) | ((bx[i] ^ by[i]) & c);
      end
      rc = c;
    end

    // Skip path kept as its own OR term so timing tools see the bypass
    assign blk_co[b] = rc | (p & blk_ci[b]);
    assign sum_all[HI-1:LO] = bs;
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO = k * SBITS;
    localparam int HI = ((k + 1) * SBITS < WIDTH) ? (k + 1) * SBITS : WIDTH;
    localparam int LB = (((k + 1) * PIPE_BLKS < NBLK) ? (k + 1) * PIPE_BLKS : NBLK) - 1;
    localparam logic [WIDTH-1:0] M_LATER = mask_from(HI);
    localparam logic [WIDTH-1:0] M_HERE  = mask_from(LO) & ~M_LATER;

    logic             vin;
    logic             ld;
    logic [WIDTH-1:0] s_k;
    logic             c_k;

    if (k == 0) begin : g_in
      assign vin   = bus.in_valid;
      assign xi[0] = bus.in_x;
      assign yi[0] = bus.in_sub ? ~bus.in_y : bus.in_y;
      assign ci[0] = bus.in_sub | bus.in_ci;
      assign si[0] = '0;
    end else begin : g_link
      assign vin = v[k-1];
    end

    assign ld      = ~v[k] | rdy[k+1];
    assign rdy[k]  = ld;
    assign s_k     = si[k] | (sum_all & M_HERE);
    assign c_k     = blk_co[LB];

    if (k < NSTG - 1) begin : g_mid
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] x_q;
      logic [WIDTH-1:0] y_q;
      logic [WIDTH-1:0] s_q;

      // Consumed operand bits are dropped so only bits for later blocks travel on
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          x_q <= '0;
          y_q <= '0;
          s_q <= '0;
        end else if (ld) begin
          v_q <= vin;
          if (vin) begin
            x_q <= xi[k] & M_LATER;
            y_q <= yi[k] & M_LATER;
            c_q <= c_k;
            s_q <= s_k;
          end
        end
      end

      assign v[k]    = v_q;
      assign xi[k+1] = x_q;
      assign yi[k+1] = y_q;
      assign ci[k+1] = c_q;
      assign si[k+1] = s_q;
    end else begin : g_out
      logic           v_q;
      logic           ovf_q;
      logic           ovf_d;
      logic [WIDTH:0] s_q;

      assign ovf_d = (xi[k][WIDTH-1] == yi[k][WIDTH-1]) & (s_k[WIDTH-1] != xi[k][WIDTH-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          ovf_q <= 1'b0;
          s_q   <= '0;
        end else if (ld) begin
          v_q <= vin;
          if (vin) begin
            s_q   <= {c_k, s_k};
            ovf_q <= ovf_d;
          end
        end
      end

      assign v[k]          = v_q;
      assign bus.out_valid = v_q;
      assign bus.out_s     = s_q;
      assign bus.out_ovf   = ovf_q;
    end
  end

  assign rdy[NSTG]    = bus.out_ready;
  assign bus.in_ready = rdy[0];
endmodule
